// File: rtl/register_file_dump.sv
`default_nettype none
// ============================================================================
// Module      : register_file_dump
// Description : Sequential reader that walks a range of register file
//               entries through both read ports (idx, idx+1) and streams
//               each word out on a valid/ready interface in ascending
//               index order, wrapping modulo NUM_REGS.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_dump #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_index,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_ISSUE  = 3'd1;
    localparam logic [2:0] c_S_WAIT   = 3'd2;
    localparam logic [2:0] c_S_SEND_A = 3'd3;
    localparam logic [2:0] c_S_SEND_B = 3'd4;
    localparam logic [2:0] c_S_FINISH = 3'd5;

    // Highest register index; increments past it wrap to zero.
    localparam logic [ADDR_W-1:0] c_MAX_IDX = ADDR_W'(NUM_REGS - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_hold_a;
    logic [DATA_W-1:0] r_hold_b;
    logic [ADDR_W-1:0] w_idx_p1;
    logic [ADDR_W-1:0] w_idx_p2;
    logic              w_last_a;
    logic              w_last_b;
    logic              w_busy;

    assign w_idx_p1 = (r_idx == c_MAX_IDX)    ? '0 : r_idx + ADDR_W'(1);
    assign w_idx_p2 = (w_idx_p1 == c_MAX_IDX) ? '0 : w_idx_p1 + ADDR_W'(1);
    assign w_last_a = (r_idx == r_end);
    assign w_last_b = (w_idx_p1 == r_end);
    assign w_busy   = (r_state != c_S_IDLE);

    // State register; async reset drops any in-flight word immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a pair is issued, waited on, then sent A then B.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_state_nxt = c_S_ISSUE;
            c_S_ISSUE:  w_state_nxt = c_S_WAIT;
            c_S_WAIT:   w_state_nxt = c_S_SEND_A;
            c_S_SEND_A: if (dump_ready) w_state_nxt = w_last_a ? c_S_FINISH : c_S_SEND_B;
            c_S_SEND_B: if (dump_ready) w_state_nxt = w_last_b ? c_S_FINISH : c_S_ISSUE;
            c_S_FINISH: w_state_nxt = c_S_IDLE;
            default:    w_state_nxt = c_S_IDLE;
        endcase
    end

    // Range latch, pair capture from the regfile and index advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= '0;
            r_end    <= '0;
            r_hold_a <= '0;
            r_hold_b <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_idx <= first_reg;
                        r_end <= last_reg;
                    end
                end
                c_S_WAIT: begin
                    r_hold_a <= ReadData1;
                    r_hold_b <= ReadData2;
                end
                c_S_SEND_B: begin
                    if (dump_ready && !w_last_b) begin
                        r_idx <= w_idx_p2;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read addresses are only driven while the reader owns the mux.
    assign ReadRegister1 = w_busy ? r_idx    : '0;
    assign ReadRegister2 = w_busy ? w_idx_p1 : '0;

    // Stream outputs come straight from held state, so they stay bit-stable
    // under backpressure and read as zero outside the send states.
    assign dump_valid = (r_state == c_S_SEND_A) || (r_state == c_S_SEND_B);
    assign dump_data  = (r_state == c_S_SEND_A) ? r_hold_a :
                        (r_state == c_S_SEND_B) ? r_hold_b : '0;
    assign dump_index = (r_state == c_S_SEND_A) ? r_idx    :
                        (r_state == c_S_SEND_B) ? w_idx_p1 : '0;
    assign dump_last  = ((r_state == c_S_SEND_A) && w_last_a) ||
                        ((r_state == c_S_SEND_B) && w_last_b);
    assign busy       = w_busy;
    assign done       = (r_state == c_S_FINISH);

endmodule
`default_nettype wire
